// File: rtl/instr_reg.sv
// ============================================================================
// Module      : instr_reg
// Description : Instruction register capturing an opcode, a short address and
//               a full address byte from a byte-wide fetch stream.
//               Optional feature macro: INSTR_REG_DUAL_LOAD_EN (fetch=11 loads
//               all three registers at once; otherwise fetch=11 holds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] fetch,
    input  logic [7:0] data,
    output logic [2:0] ins,
    output logic [4:0] ad1,
    output logic [7:0] ad2
);

    localparam logic [1:0] C_FETCH_HOLD = 2'b00;
    localparam logic [1:0] C_FETCH_B1   = 2'b01;
    localparam logic [1:0] C_FETCH_B2   = 2'b10;
    localparam logic [1:0] C_FETCH_BOTH = 2'b11;

    logic [2:0] r_ins;
    logic [4:0] r_ad1;
    logic [7:0] r_ad2;

    logic       w_load_ins;
    logic       w_load_ad1;
    logic       w_load_ad2;

    // Per-register load enables decoded from the fetch command.
    always_comb begin
        w_load_ins = 1'b0;
        w_load_ad1 = 1'b0;
        w_load_ad2 = 1'b0;
        case (fetch)
            C_FETCH_HOLD: begin
                w_load_ins = 1'b0;
            end
            C_FETCH_B1: begin
                w_load_ins = 1'b1;
                w_load_ad1 = 1'b1;
            end
            C_FETCH_B2: begin
                w_load_ins = 1'b1;
                w_load_ad2 = 1'b1;
            end
            C_FETCH_BOTH: begin
`ifdef INSTR_REG_DUAL_LOAD_EN
                w_load_ins = 1'b1;
                w_load_ad1 = 1'b1;
                w_load_ad2 = 1'b1;
`else
                w_load_ins = 1'b0;
`endif
            end
            default: begin
                w_load_ins = 1'b0;
            end
        endcase
    end

    // Reset wins over any load in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ins <= 3'b000;
            r_ad1 <= 5'b00000;
            r_ad2 <= 8'h00;
        end else begin
            if (w_load_ins) begin
                r_ins <= data[7:5];
            end
            if (w_load_ad1) begin
                r_ad1 <= data[4:0];
            end
            if (w_load_ad2) begin
                r_ad2 <= data;
            end
        end
    end

    assign ins = r_ins;
    assign ad1 = r_ad1;
    assign ad2 = r_ad2;

endmodule

`default_nettype wire

// File: tb/tb_instr_reg.sv
// ============================================================================
// Module      : tb_instr_reg
// Description : Self-checking bench for instr_reg with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_reg;

    logic       clk;
    logic       rst;
    logic [1:0] fetch;
    logic [7:0] data;
    logic [2:0] ins;
    logic [4:0] ad1;
    logic [7:0] ad2;

    logic [2:0] m_ins;
    logic [4:0] m_ad1;
    logic [7:0] m_ad2;

    int errors = 0;
    int checks = 0;

    instr_reg dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (fetch),
        .data  (data),
        .ins   (ins),
        .ad1   (ad1),
        .ad2   (ad2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction byte splits into opcode (top 3 bits)
    // and short address (low 5 bits); the operand byte is the full address.
    task automatic model(input logic r, input logic [1:0] f, input logic [7:0] d);
        bit dual;
`ifdef INSTR_REG_DUAL_LOAD_EN
        dual = 1'b1;
`else
        dual = 1'b0;
`endif
        if (r == 1'b0) begin
            m_ins = 3'd0;
            m_ad1 = 5'd0;
            m_ad2 = 8'd0;
        end else if (f == 2'd1) begin
            m_ins = d[7:5];
            m_ad1 = d[4:0];
        end else if (f == 2'd2) begin
            m_ins = d[7:5];
            m_ad2 = d;
        end else if (f == 2'd3 && dual) begin
            m_ins = d[7:5];
            m_ad1 = d[4:0];
            m_ad2 = d;
        end
    endtask

    task automatic check(input string tag);
        checks++;
        assert (ins === m_ins) else begin
            errors++;
            $error("FAIL %s ins observed=%b expected=%b", tag, ins, m_ins);
        end
        checks++;
        assert (ad1 === m_ad1) else begin
            errors++;
            $error("FAIL %s ad1 observed=%b expected=%b", tag, ad1, m_ad1);
        end
        checks++;
        assert (ad2 === m_ad2) else begin
            errors++;
            $error("FAIL %s ad2 observed=%h expected=%h", tag, ad2, m_ad2);
        end
    endtask

    task automatic expect_const(input string tag, input logic [2:0] ei,
                                input logic [4:0] ea1, input logic [7:0] ea2);
        checks++;
        assert (ins === ei && ad1 === ea1 && ad2 === ea2) else begin
            errors++;
            $error("FAIL %s observed=%b/%b/%h expected=%b/%b/%h",
                   tag, ins, ad1, ad2, ei, ea1, ea2);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] f, input logic [7:0] d,
                        input string tag);
        rst   = r;
        fetch = f;
        data  = d;
        @(posedge clk);
        #1;
        model(r, f, d);
        check(tag);
    endtask

    // Pulse a load command between edges; it must not be captured.
    task automatic glitch(input string tag);
        rst   = 1'b1;
        fetch = 2'b01;
        data  = 8'($urandom);
        #2;
        fetch = 2'b10;
        data  = 8'($urandom);
        #2;
        fetch = 2'b00;
        data  = 8'($urandom);
        @(posedge clk);
        #1;
        model(1'b1, 2'b00, data);
        check(tag);
    endtask

    initial begin
        rst   = 1'b0;
        fetch = 2'b00;
        data  = 8'h00;
        m_ins = 3'd0;
        m_ad1 = 5'd0;
        m_ad2 = 8'd0;

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'($urandom), 8'($urandom), "reset_hold");
        end
        expect_const("reset_const", 3'b000, 5'b00000, 8'h00);

        step(1'b1, 2'b01, 8'b01011100, "load_b1");
        expect_const("load_b1_const", 3'b010, 5'b11100, 8'h00);

        step(1'b1, 2'b10, 8'b10101111, "load_b2");
        expect_const("load_b2_const", 3'b101, 5'b11100, 8'b10101111);

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b00, (i % 2 == 0) ? 8'hFF : 8'h00, "hold");
        end
        expect_const("hold_const", 3'b101, 5'b11100, 8'b10101111);

        step(1'b0, 2'b01, 8'hFF, "reset_prio");
        expect_const("reset_prio_const", 3'b000, 5'b00000, 8'h00);

        // Preload nonzero values so a hold on fetch=11 is observable.
        step(1'b1, 2'b10, 8'h5A, "pre_b2");
        step(1'b1, 2'b01, 8'h33, "pre_b1");
        step(1'b1, 2'b11, 8'hC7, "fetch11");
`ifdef INSTR_REG_DUAL_LOAD_EN
        expect_const("fetch11_const", 3'b110, 5'b00111, 8'hC7);
`else
        expect_const("fetch11_const", 3'b001, 5'b10011, 8'h5A);
`endif

        for (int i = 0; i < 4; i++) begin
            glitch("midcycle");
        end

        // Mid-sequence reset: byte 1 loaded, reset lands before byte 2.
        step(1'b1, 2'b01, 8'hE9, "seq_b1");
        step(1'b0, 2'b10, 8'h77, "seq_reset");
        step(1'b1, 2'b10, 8'h77, "seq_b2");

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1,
                 2'($urandom), 8'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/instr_reg.md
INSTR_REG -- requirements
Module: instr_reg

Interface
REQ-001 The block SHALL have one clock, with synchronous active-low reset; all state changes occur on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: clock; all registers sample on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-low reset; sampled only on the rising edge of clk.
REQ-004 Port fetch, input, 2 bits: load command (00 hold, 01 load byte 1, 10 load byte 2, 11 see REQ-011).
REQ-005 Port data, input, 8 bits: instruction or operand byte to capture.
REQ-006 Port ins, output, 3 bits: opcode register.
REQ-007 Port ad1, output, 5 bits: short-address register (low field of byte 1).
REQ-008 Port ad2, output, 8 bits: full-address register (byte 2).
REQ-009 Parameters: none.

Function
REQ-010 On each rising edge with rst=1, the block SHALL act on fetch as follows:
- fetch=01: ins <= data[7:5]; ad1 <= data[4:0]; ad2 holds.
- fetch=10: ins <= data[7:5]; ad2 <= data[7:0]; ad1 holds.
- fetch=00: all registers hold.
REQ-011 With rst=1 and fetch=11, the behaviour depends on the configuration macro (REQ-017/REQ-018).
REQ-012 Outputs SHALL be driven directly from registers, with no combinational path from data or fetch to any output; load latency is one clock edge.
REQ-013 data and fetch SHALL be sampled only at the rising edge; changes between edges have no effect.

Reset
REQ-014 When rst=0 at a rising edge, the block SHALL set ins=3'b000, ad1=5'b00000 and ad2=8'h00, regardless of fetch.
REQ-015 Reset SHALL take priority over any fetch command in the same cycle, including reset asserted in the middle of a load sequence.
REQ-016 Before the first rising edge with rst=0, output values are undefined; no asynchronous clear exists.

Configuration
REQ-017 With macro INSTR_REG_DUAL_LOAD_EN defined, fetch=11 with rst=1 SHALL load all three registers in one edge: ins <= data[7:5], ad1 <= data[4:0], ad2 <= data.
REQ-018 With INSTR_REG_DUAL_LOAD_EN not defined, fetch=11 SHALL be treated as hold, identical to fetch=00.
REQ-019 The macro SHALL change no port and no other behaviour.

Verification
REQ-020 Hold rst=0 for 10 edges with random fetch and data -> ins=000, ad1=00000, ad2=00h after the first edge.
REQ-021 Release reset, then fetch=01 with data=8'b01011100 for one edge -> ins=010, ad1=11100, ad2=00000000.
REQ-022 Next, fetch=10 with data=8'b10101111 -> ins=101, ad1=11100 (unchanged), ad2=10101111.
REQ-023 fetch=00 with data toggling for 5 edges -> all outputs unchanged.
REQ-024 Assert rst=0 together with fetch=01 and data=FFh -> all outputs 0 after that edge.
REQ-025 fetch=11 with data=8'hC7:
- macro defined -> ins=110, ad1=00111, ad2=C7h.
- macro undefined -> all outputs unchanged.
